// File: rtl/fifo_unpack_reader.sv
// fifo_unpack_reader
//   Pops wide words from a show-ahead FIFO, holds each one, and streams it
//   out as RATIO = IN_WIDTH/OUT_WIDTH narrow sub-words on a valid/ready
//   interface. Sustains one sub-word per cycle across word boundaries.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   fifo_empty     FIFO has no word (fifo_read_data invalid while high)
//   fifo_read_data head-of-FIFO word, show-ahead
//   fifo_read_en   pop strobe; FIFO advances on an edge where this is high
//   flush          synchronous discard of the held word
//   out_valid      out_data holds a sub-word
//   out_ready      sink accepts; transfer on out_valid && out_ready
//   out_data       current sub-word
//   out_last       current sub-word is the last of its FIFO word
//   busy           a word is held (same as out_valid)
module fifo_unpack_reader #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_read_data,
  output logic                 fifo_read_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [IN_WIDTH-1:0]   hold_reg, hold_nxt;
  logic [CNT_WIDTH-1:0]  sel;
  logic                  take, last_take, pop;

  assign out_valid = (state == ST_HOLD);
  assign busy      = out_valid;
  assign out_last  = out_valid && (cnt == CNT_LAST);
  assign take      = out_valid && out_ready;
  assign last_take = take && (cnt == CNT_LAST);

  // Gating with reset keeps the FIFO from popping while reset is held.
  assign pop          = reset && !fifo_empty && !flush &&
                        ((state == ST_EMPTY) || last_take);
  assign fifo_read_en = pop;

  assign sel = LSB_FIRST ? cnt : (CNT_LAST - cnt);

  // Constant-index mux over the sub-words of the held word.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sel == CNT_WIDTH'(i)) begin
        out_data = hold_reg[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold_reg;
    if (flush) begin
      state_nxt = ST_EMPTY;
      cnt_nxt   = '0;
    end else if (pop) begin
      // Covers both the idle fetch and the refill on the final sub-word.
      state_nxt = ST_HOLD;
      cnt_nxt   = '0;
      hold_nxt  = fifo_read_data;
    end else if (last_take) begin
      state_nxt = ST_EMPTY;
      cnt_nxt   = '0;
    end else if (take) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      cnt      <= '0;
      hold_reg <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_reg <= hold_nxt;
    end
  end

endmodule

// File: doc/fifo_unpack_reader.md
# fifo_unpack_reader

Read-side consumer for the show-ahead FIFO read interface (`read_en`/`empty`/`read_data`). It pops wide words from the FIFO, holds each one, and emits it as a sequence of narrow sub-words on a valid/ready stream. It sits in the consumer clock domain between a clock-crossing FIFO and a narrow sink such as a byte-serial peripheral. Sustained throughput is one sub-word per cycle, with no bubble between words.

## Interface
- `IN_WIDTH`, 32, FIFO word width; must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 8, output sub-word width.
- `LSB_FIRST`, 1, 1 = emit bits [OUT_WIDTH-1:0] first; 0 = emit MSB sub-word first.
- Derived: `RATIO = IN_WIDTH/OUT_WIDTH` (must be ≥ 2); `CNT_WIDTH = $clog2(RATIO)`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO has no word; `fifo_read_data` is invalid while high.
- `fifo_read_data`  in  IN_WIDTH  head-of-FIFO word, show-ahead (valid while `fifo_empty` = 0).
- `fifo_read_en`  out  1  pop strobe; the FIFO advances on a clock edge where this is high.
- `flush`  in  1  synchronous discard of the held word.
- `out_valid`  out  1  `out_data` holds a sub-word.
- `out_ready`  in  1  sink accepts; a transfer occurs when `out_valid && out_ready`.
- `out_data`  out  OUT_WIDTH  current sub-word.
- `out_last`  out  1  current sub-word is the final one of its FIFO word.
- `busy`  out  1  a word is held (equals `out_valid`).

## Operation
- State: EMPTY (nothing held) or HOLD (word in `hold_reg`, index `cnt` in 0..RATIO-1).
- `take` = `out_valid && out_ready`; `last_take` = `take && cnt == RATIO-1`.
- `fifo_read_en` (combinational) = `!fifo_empty && !flush && (state == EMPTY || last_take)`. It is never high while `fifo_empty` = 1.
- On a pop: `hold_reg <= fifo_read_data`, `cnt <= 0`, state becomes HOLD.
- `take` without `last_take`: `cnt <= cnt + 1`; `hold_reg` is unchanged.
- `last_take` without a pop: state becomes EMPTY and `cnt <= 0`.
- `last_take` with a pop: state stays HOLD with the new word, which is presented on the next cycle.
- `out_data`:
  - `LSB_FIRST` = 1: `hold_reg[cnt*OUT_WIDTH +: OUT_WIDTH]`.
  - `LSB_FIRST` = 0: `hold_reg[(RATIO-1-cnt)*OUT_WIDTH +: OUT_WIDTH]`.
- `out_last` = HOLD && `cnt == RATIO-1`.
- `out_valid` = HOLD. While `out_ready` = 0, `out_data` and `out_last` stay stable; `out_valid` never drops without a transfer, except on flush or reset.
- `flush` has priority over everything:
  - Next state is EMPTY and `cnt <= 0`.
  - No pop occurs that cycle.
  - A sub-word offered in the same cycle with `out_ready` = 1 counts as transferred. The remainder of its word is discarded.
- `cnt` wraps only via the `last_take` rule. Values ≥ RATIO are unreachable; a bench assertion checks this.

## Timing
- Reset (`reset` = 0, asynchronous):
  - state = EMPTY, `cnt` = 0, `hold_reg` = 0.
  - Outputs: `out_valid` = 0, `out_last` = 0, `busy` = 0, `out_data` = 0.
  - `fifo_read_en` is forced to 0 while reset is asserted.
- Reset deassertion is assumed synchronized to `clk` externally.
- Latency: `fifo_empty` falls at cycle N → `fifo_read_en` = 1 at N → `out_valid` = 1 at N+1.
- With the sink always ready and the FIFO never empty: RATIO sub-words per RATIO cycles, back-to-back across word boundaries, one pop every RATIO cycles.
- Reset asserted mid-word: the held word is lost, and no pop is issued in the reset cycle.

## Test plan
- Reset check: hold `reset` low with `fifo_empty` = 0 → `fifo_read_en` = 0, `out_valid` = 0, `out_data` = 0.
- Single word, LSB_FIRST = 1: FIFO holds 0x44332211, `out_ready` = 1 → `out_data` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `out_last` only on 0x44, exactly one `fifo_read_en` pulse.
- Back-to-back words: FIFO holds 0xDDCCBBAA then 0x04030201, sink always ready → 8 consecutive beats with no bubble; second pop coincides with the 0xDD transfer.
- Backpressure: toggle `out_ready` randomly on word 0xA5A55A5A → each byte is held stable until accepted, and there is no pop until the last byte is taken.
- Flush mid-word: after bytes 0x11 and 0x22 of 0x44332211, assert `flush` for one cycle with the next word 0x88776655 pending → `out_valid` = 0 on the next cycle; then 0x55, 0x66, 0x77, 0x88 follow; 0x33 and 0x44 never appear.
- MSB-first: `LSB_FIRST` = 0 and word 0x44332211 → 0x44, 0x33, 0x22, 0x11; a FIFO underflow assertion (`fifo_read_en && fifo_empty`) never fires.
